// File: rtl/ysyx_24090018_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one fetch at a time,
// hands the instruction downstream and waits for EXU completion before advancing.
module ysyx_24090018_ifu #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_addr_o,
  input  logic                  exu_done_i,
  input  logic                  jump_flag_i,
  input  logic [DATA_WIDTH-1:0] jump_addr_i,
  output logic                  misalign_o,
  output logic                  fetch_err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    EXEC = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;

  // Handshake events, each qualified by the state in which it is meaningful.
  logic rsp_ok, rsp_err, redirect_done;
  assign rsp_ok        = (state_q == WAIT) && imem_rsp_valid_i && !imem_rsp_err_i;
  assign rsp_err       = (state_q == WAIT) && imem_rsp_valid_i &&  imem_rsp_err_i;
  assign redirect_done = (state_q == EXEC) && exu_done_i;

  // NOTE: state-register process uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_req_ready_i) state_d = WAIT;
      WAIT: if (imem_rsp_valid_i) state_d = imem_rsp_err_i ? ERR : HOLD;
      HOLD: if (inst_ready_i) state_d = EXEC;
      EXEC: if (exu_done_i) state_d = REQ;
      ERR:  state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here, including the instruction latch, is reset so
  // the outputs are defined immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inst_o      <= '0;
      inst_addr_o <= '0;
      misalign_o  <= 1'b0;
      fetch_err_o <= 1'b0;
    end else begin
      if (rsp_ok) begin
        inst_o      <= imem_rsp_data_i;
        inst_addr_o <= pc_q;
      end
      if (rsp_err) fetch_err_o <= 1'b1;
      if (redirect_done) begin
        if (jump_flag_i) begin
          pc_q <= {jump_addr_i[DATA_WIDTH-1:2], 2'b00};
          if (jump_addr_i[1:0] != 2'b00) misalign_o <= 1'b1;
        end else begin
          pc_q <= pc_q + DATA_WIDTH'(4);
        end
      end
    end
  end

  // All handshake outputs are pure state decodes: no combinational imem path.
  assign imem_req_valid_o = (state_q == REQ);
  assign imem_addr_o      = pc_q;
  assign inst_valid_o     = (state_q == HOLD);

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// Directed self-checking bench for ysyx_24090018_ifu: reset, backpressure,
// redirect, misalignment, PC wrap, spurious done, fetch error and mid-WAIT reset.
`timescale 1ns/1ps
module tb_ysyx_24090018_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        exu_done_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        misalign_o;
  logic        fetch_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  ysyx_24090018_ifu #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_addr_o      (inst_addr_o),
    .exu_done_i       (exu_done_i),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .misalign_o       (misalign_o),
    .fetch_err_o      (fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for a few cycles, release at a falling edge, then expect a request
  // at RESET_PC within two rising edges.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_idle_no_req"}, {31'd0, imem_req_valid_o}, 32'd0);
    tick();
    tick();
    check({tag, "_first_req_valid"}, {31'd0, imem_req_valid_o}, 32'd1);
    check({tag, "_first_req_addr"}, imem_addr_o, 32'h8000_0000);
  endtask

  // From REQ: zero-wait accept and response, downstream accepts at once; ends in EXEC.
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    imem_rsp_err_i   = 1'b0;
    tick();
    imem_rsp_valid_i = 1'b0;
    inst_ready_i     = 1'b1;
    tick();
    inst_ready_i     = 1'b0;
  endtask

  // From EXEC: one-cycle done pulse with the given redirect; ends in REQ.
  task automatic do_done(input logic jump, input logic [31:0] target);
    exu_done_i  = 1'b1;
    jump_flag_i = jump;
    jump_addr_i = target;
    tick();
    exu_done_i  = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'd0;
  endtask

  initial begin
    rst_n            = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    imem_rsp_err_i   = 1'b0;
    inst_ready_i     = 1'b0;
    exu_done_i       = 1'b0;
    jump_flag_i      = 1'b0;
    jump_addr_i      = 32'd0;

    // Reset values.
    repeat (2) tick();
    check("rst_req_valid",  {31'd0, imem_req_valid_o}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst",       inst_o, 32'd0);
    check("rst_misalign",   {31'd0, misalign_o}, 32'd0);
    check("rst_fetch_err",  {31'd0, fetch_err_o}, 32'd0);
    check("rst_pc",         imem_addr_o, 32'h8000_0000);

    do_reset("boot");

    // Request backpressure: valid and address stay put.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      check("bp_req_addr",  imem_addr_o, 32'h8000_0000);
    end

    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    check("wait_req_dropped", {31'd0, imem_req_valid_o}, 32'd0);
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0000_0413;
    tick();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    check("hold_inst_valid", {31'd0, inst_valid_o}, 32'd1);
    check("hold_inst",       inst_o, 32'h0000_0413);
    check("hold_inst_addr",  inst_addr_o, 32'h8000_0000);

    // Downstream backpressure: instruction held.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ibp_inst_valid", {31'd0, inst_valid_o}, 32'd1);
      check("ibp_inst",       inst_o, 32'h0000_0413);
    end

    // Done coincident with HOLD->EXEC must be ignored.
    inst_ready_i = 1'b1;
    exu_done_i   = 1'b1;
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h0000_1234;
    tick();
    inst_ready_i = 1'b0;
    exu_done_i   = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 32'd0;
    check("exec_inst_valid_dropped", {31'd0, inst_valid_o}, 32'd0);
    check("exec_no_req",             {31'd0, imem_req_valid_o}, 32'd0);
    tick();
    check("exec_still_waiting", {31'd0, imem_req_valid_o}, 32'd0);

    do_done(1'b0, 32'd0);
    check("seq_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("seq_req_addr",  imem_addr_o, 32'h8000_0004);

    // Aligned redirect.
    do_fetch(32'h0000_0013);
    check("second_inst_addr", inst_addr_o, 32'h8000_0004);
    do_done(1'b1, 32'h8000_0100);
    check("jump_addr",     imem_addr_o, 32'h8000_0100);
    check("jump_misalign", {31'd0, misalign_o}, 32'd0);

    // Misaligned redirect: target truncated, flag sticky.
    do_fetch(32'h0000_0013);
    do_done(1'b1, 32'h8000_0102);
    check("mis_jump_addr", imem_addr_o, 32'h8000_0100);
    check("mis_flag",      {31'd0, misalign_o}, 32'd1);
    do_fetch(32'h0000_0013);
    do_done(1'b0, 32'd0);
    check("mis_seq_addr",   imem_addr_o, 32'h8000_0104);
    check("mis_flag_stick", {31'd0, misalign_o}, 32'd1);

    // PC wrap.
    do_fetch(32'h0000_0013);
    do_done(1'b1, 32'hFFFF_FFFC);
    check("wrap_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013);
    do_done(1'b0, 32'd0);
    check("wrap_zero_addr", imem_addr_o, 32'h0000_0000);

    // Spurious done during WAIT is ignored.
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    exu_done_i  = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0040;
    tick();
    exu_done_i  = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'd0;
    check("spur_pc_unchanged", imem_addr_o, 32'h0000_0000);
    check("spur_no_req",       {31'd0, imem_req_valid_o}, 32'd0);
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h00A0_0093;
    tick();
    imem_rsp_valid_i = 1'b0;
    check("spur_inst_addr", inst_addr_o, 32'h0000_0000);
    check("spur_inst",      inst_o, 32'h00A0_0093);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    do_done(1'b0, 32'd0);
    check("spur_next_addr", imem_addr_o, 32'h0000_0004);

    // Fetch error: terminal until reset.
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_err_i   = 1'b1;
    tick();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    check("err_flag",       {31'd0, fetch_err_o}, 32'd1);
    check("err_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    imem_req_ready_i = 1'b1;
    inst_ready_i     = 1'b1;
    exu_done_i       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("err_no_req",   {31'd0, imem_req_valid_o}, 32'd0);
      check("err_no_inst",  {31'd0, inst_valid_o}, 32'd0);
      check("err_sticky",   {31'd0, fetch_err_o}, 32'd1);
    end
    imem_req_ready_i = 1'b0;
    inst_ready_i     = 1'b0;
    exu_done_i       = 1'b0;

    // Reset clears sticky flags and restarts at RESET_PC.
    do_reset("rerst");
    check("rerst_fetch_err", {31'd0, fetch_err_o}, 32'd0);
    check("rerst_misalign",  {31'd0, misalign_o}, 32'd0);

    // Fill the instruction latch, then reset mid-WAIT of the next fetch.
    do_fetch(32'h1234_5678);
    do_done(1'b0, 32'd0);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid",  {31'd0, imem_req_valid_o}, 32'd0);
    check("mid_rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("mid_rst_pc",         imem_addr_o, 32'h8000_0000);
    check("mid_rst_inst",       inst_o, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    // Late response straddling IDLE and REQ.
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    check("late_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("late_req_addr",  imem_addr_o, 32'h8000_0000);
    tick();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    check("late_ignored_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("late_ignored_inst",       inst_o, 32'd0);
    check("late_still_req",          {31'd0, imem_req_valid_o}, 32'd1);

    do_fetch(32'h0010_0093);
    check("restart_inst",      inst_o, 32'h0010_0093);
    check("restart_inst_addr", inst_addr_o, 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
